queue_param: RTL and testbench
==============================

Name: queue_param

Overview:
- Parametrised synchronous FIFO queue; successor to the fixed 8-bit queue.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between producer and consumer blocks in one clock domain; drop-in for the old queue when the extra outputs are left unconnected.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of storage entries (>=2; need not be a power of two).
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wr  input  1  write request.
- rd  input  1  read request.
- din  input  DATA_W  write data.
- dout  output  DATA_W  read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  CNT_W  current occupancy.
- overflow  output  1  sticky: a write was attempted while full and not accepted.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; dout goes to 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all queued data immediately.
  - Reset deassertion is synchronised by the integrator; the block samples inputs from the first clk edge after reset=1.
- Acceptance, evaluated each rising edge:
  - wr_ok = wr & (~full | rd).
  - rd_ok = rd & ~empty.
- Write: if wr_ok, mem[wr_ptr] <= din; wr_ptr advances. When wr_ptr == DEPTH-1 it wraps to 0 (explicit compare, no power-of-two masking).
- Read (default mode): if rd_ok, dout <= mem[rd_ptr] and rd_ptr advances with the same wrap rule. Latency is 1 clock: data appears on dout after the edge that accepted rd. dout holds its value when no read is accepted.
- Count update:
  - +1 when wr_ok & ~rd_ok.
  - -1 when rd_ok & ~wr_ok.
  - Unchanged otherwise.
- Flags are combinational decodes of registered count, so they are valid the cycle after the edge that changed count.
- Simultaneous wr & rd:
  - Empty: only the write is accepted; no bypass. Count goes to 1 and underflow sets.
  - Full: both are accepted; count stays DEPTH. The read returns the oldest entry, and the write goes into the slot just freed.
  - Otherwise: both are accepted; count unchanged.
- Errors:
  - overflow sets on an edge with wr & full & ~rd.
  - underflow sets on an edge with rd & empty.
  - Both are sticky until reset.
  - A rejected operation does not modify pointers, memory, count or dout.
- No state machine beyond pointers and count. Pointers are $clog2(DEPTH) bits, minimum 1.

Optional Feature:
- Macro QUEUE_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously presents mem[rd_ptr] whenever empty=0, with zero read latency.
  - rd acts as a pop acknowledge; dout shows the next entry the cycle after rd_ok.
  - dout is 0 while empty.
  - Acceptance, count, flags and errors are unchanged.
- Undefined: registered 1-cycle read latency as described in Behaviour.

Test Plan (DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, default mode unless stated):
- Reset then idle -> empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0x00, overflow=0, underflow=0.
- Write 0x0A,0x01,0x02,0x04 on four consecutive cycles, then read four times -> count steps 1,2,3,4 (almost_full at 3, full at 4); dout=0x0A,0x01,0x02,0x04 one cycle after each read; empty=1 at end.
- Fill to 4, then assert wr=1 with din=0x99 and rd=0 -> overflow=1 and count stays 4. Then assert wr=1 with din=0x55 and rd=1 together -> dout=head value, count=4. Drain -> 0x55 is the last word out.
- rd=1 while empty -> underflow=1, dout unchanged, count=0. Then wr=1 with din=0x07 and rd=1 together -> count=1, next read returns 0x07.
- Run 10 write/read pairs (one write then one read, alternating) with data 0x10..0x19 -> pointers wrap past index 3; every read returns the matching value in order.
- With QUEUE_FWFT_EN: write 0x03 -> dout=0x03 on the cycle after the write, without rd. Pop -> empty=1 and dout=0x00.

Source files
------------

// File: rtl/queue_param.sv
`default_nettype none
// ============================================================================
// queue_param : parametrised synchronous FIFO with occupancy count,
//               almost-full/almost-empty flags and sticky overflow/underflow.
// Optional: define QUEUE_FWFT_EN for first-word-fall-through read data.
// Revision   : 1.0
// ============================================================================
module queue_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int               PTR_W    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);

    // A write into a full queue is accepted when a read frees the head slot.
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (wr_ok & ~rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok & ~wr_ok) begin
                count <= count - CNT_W'(1);
            end
            if (wr & full & ~rd) begin
                overflow <= 1'b1;
            end
            if (rd & empty) begin
                underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

`ifdef QUEUE_FWFT_EN
    assign dout = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[rd_ptr];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_queue_param.sv
`default_nettype none
// Testbench for queue_param: directed vector table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_queue_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int AE_LEVEL = 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              wr    = 1'b0;
    logic              rd    = 1'b0;
    logic [DATA_W-1:0] din   = '0;
    logic [DATA_W-1:0] dout;
    logic              empty, full, almost_empty, almost_full;
    logic              overflow, underflow;
    logic [CNT_W-1:0]  count;

    queue_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .din         (din),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a plain queue plus sticky error bits.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    typedef struct {
        bit         w;
        bit         r;
        logic [7:0] d;
        int         cnt;
        bit         e, f, ae, af, ov, un;
        logic [7:0] dq;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [7:0] d);
        bit was_empty = (mq.size() == 0);
        bit was_full  = (mq.size() == DEPTH);
        if (w && was_full && !r) m_ovf = 1'b1;
        if (r && was_empty)      m_unf = 1'b1;
        if (r && !was_empty)     m_dout = mq.pop_front();
        if (w && (!was_full || r)) mq.push_back(d);
    endtask

    function automatic logic [7:0] exp_dout();
`ifdef QUEUE_FWFT_EN
        return (mq.size() != 0) ? mq[0] : 8'h00;
`else
        return m_dout;
`endif
    endfunction

    task automatic check_model(input string tag);
        int n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE_LEVEL));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF_LEVEL));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".dout"}, 32'(dout), 32'(exp_dout()));
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        model_step(w, r, d);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        //         w  r  din    cnt e  f  ae af ov un dout
        tbl[0]  = '{1, 0, 8'h0A, 1, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 0, 8'h01, 2, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{1, 0, 8'h02, 3, 0, 0, 0, 1, 0, 0, 8'h00};
        tbl[3]  = '{1, 0, 8'h04, 4, 0, 1, 0, 1, 0, 0, 8'h00};
        tbl[4]  = '{0, 1, 8'h00, 3, 0, 0, 0, 1, 0, 0, 8'h0A};
        tbl[5]  = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 0, 8'h01};
        tbl[6]  = '{0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h02};
        tbl[7]  = '{0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h04};
        tbl[8]  = '{1, 0, 8'h11, 1, 0, 0, 1, 0, 0, 0, 8'h04};
        tbl[9]  = '{1, 0, 8'h22, 2, 0, 0, 0, 0, 0, 0, 8'h04};
        tbl[10] = '{1, 0, 8'h33, 3, 0, 0, 0, 1, 0, 0, 8'h04};
        tbl[11] = '{1, 0, 8'h44, 4, 0, 1, 0, 1, 0, 0, 8'h04};
        tbl[12] = '{1, 0, 8'h99, 4, 0, 1, 0, 1, 1, 0, 8'h04};
        tbl[13] = '{1, 1, 8'h55, 4, 0, 1, 0, 1, 1, 0, 8'h11};
        tbl[14] = '{0, 1, 8'h00, 3, 0, 0, 0, 1, 1, 0, 8'h22};
        tbl[15] = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0, 8'h33};
        tbl[16] = '{0, 1, 8'h00, 1, 0, 0, 1, 0, 1, 0, 8'h44};
        tbl[17] = '{0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 0, 8'h55};
        tbl[18] = '{0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 1, 8'h55};
        tbl[19] = '{1, 1, 8'h07, 1, 0, 0, 1, 0, 1, 1, 8'h55};
        tbl[20] = '{0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 1, 8'h07};

        // Reset state, checked while reset is held and after release.
        model_reset();
        #12;
        check_model("in_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.almost_empty", 32'(almost_empty), 32'd1);
        chk("rst.almost_full", 32'(almost_full), 32'd0);
        chk("rst.dout", 32'(dout), 32'h00);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.underflow", 32'(underflow), 32'd0);

        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].f));
            chk($sformatf("vec%0d.almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].ov));
            chk($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(tbl[i].un));
`ifdef QUEUE_FWFT_EN
            chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(exp_dout()));
`else
            chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(tbl[i].dq));
`endif
        end

        // Alternating write/read pairs push both pointers round the ring.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h10 + i));
            chk($sformatf("pair%0d.count", i), 32'(count), 32'd1);
`ifdef QUEUE_FWFT_EN
            chk($sformatf("pair%0d.fwft_dout", i), 32'(dout), 32'(8'h10 + i));
`endif
            cycle(1'b0, 1'b1, 8'h00);
`ifdef QUEUE_FWFT_EN
            chk($sformatf("pair%0d.dout", i), 32'(dout), 32'h00);
`else
            chk($sformatf("pair%0d.dout", i), 32'(dout), 32'(8'h10 + i));
`endif
            chk($sformatf("pair%0d.empty", i), 32'(empty), 32'd1);
        end

        // Reset in the middle of traffic takes effect without a clock edge.
        cycle(1'b1, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 8'hA2);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst.count", 32'(count), 32'd0);
        chk("midrst.empty", 32'(empty), 32'd1);
        chk("midrst.dout", 32'(dout), 32'h00);
        chk("midrst.overflow", 32'(overflow), 32'd0);
        chk("midrst.underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef QUEUE_FWFT_EN
        cycle(1'b1, 1'b0, 8'h03);
        chk("fwft.show", 32'(dout), 32'h03);
        cycle(1'b0, 1'b1, 8'h00);
        chk("fwft.pop_empty", 32'(empty), 32'd1);
        chk("fwft.pop_dout", 32'(dout), 32'h00);
`endif

        // Randomized traffic: a balanced phase, then write- and read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int pw = (i < 200) ? 50 : ((i < 400) ? 80 : 25);
            int pr = (i < 200) ? 50 : ((i < 400) ? 30 : 80);
            cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
